// File: rtl/brush_stamp_engine.sv
// rtl/brush_stamp_engine.sv - square brush stamper driving the 80x60 cell frame buffer write port.
// Optional build macro ERASER_EN adds an erase input that paints white instead of colour.
module brush_stamp_engine #(
  parameter int GRID_W     = 80,
  parameter int GRID_H     = 60,
  parameter int CELL_SHIFT = 3,
  parameter int MAX_RADIUS = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        paint_req,
  input  logic [9:0]  cursor_x,
  input  logic [9:0]  cursor_y,
  input  logic [11:0] colour,
  input  logic [1:0]  brush_radius,
`ifdef ERASER_EN
  input  logic        erase,
`endif
  output logic        write_en,
  output logic [9:0]  write_x,
  output logic [9:0]  write_y,
  output logic [11:0] write_colour,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, STAMP, DONE} state_t;

  localparam logic signed [10:0] X_LIM = 11'(GRID_W);
  localparam logic signed [10:0] Y_LIM = 11'(GRID_H);
  localparam logic signed [10:0] X_MAX = 11'(GRID_W - 1);
  localparam logic signed [10:0] Y_MAX = 11'(GRID_H - 1);
  localparam logic [1:0]         R_MAX = 2'(MAX_RADIUS);

  state_t state;

  logic [10:0] cur_x, cur_y;
  logic [10:0] x0_q, x1_q, y1_q;

  logic signed [10:0] req_cx, req_cy, req_r;
  logic signed [10:0] x_lo, x_hi, y_lo, y_hi;
  logic signed [10:0] x0_c, x1_c, y0_c, y1_c;
  logic [1:0]         r_sat;
  logic [11:0]        req_colour;
  logic               out_of_grid;

  // Bounds are computed in signed arithmetic so a brush hanging off the top/left edge clips at 0.
  always_comb begin
    r_sat       = (brush_radius > R_MAX) ? R_MAX : brush_radius;
    req_cx      = signed'({1'b0, cursor_x >> CELL_SHIFT});
    req_cy      = signed'({1'b0, cursor_y >> CELL_SHIFT});
    req_r       = signed'({9'd0, r_sat});
    x_lo        = req_cx - req_r;
    x_hi        = req_cx + req_r;
    y_lo        = req_cy - req_r;
    y_hi        = req_cy + req_r;
    x0_c        = (x_lo < 0) ? 11'sd0 : x_lo;
    x1_c        = (x_hi > X_MAX) ? X_MAX : x_hi;
    y0_c        = (y_lo < 0) ? 11'sd0 : y_lo;
    y1_c        = (y_hi > Y_MAX) ? Y_MAX : y_hi;
    out_of_grid = (req_cx >= X_LIM) || (req_cy >= Y_LIM);
`ifdef ERASER_EN
    req_colour  = erase ? 12'hFFF : colour;
`else
    req_colour  = colour;
`endif
  end

  // The first write is registered on the request edge itself, so it appears the very next cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      write_en     <= 1'b0;
      write_x      <= 10'd0;
      write_y      <= 10'd0;
      write_colour <= 12'd0;
      busy         <= 1'b0;
      done         <= 1'b0;
      cur_x        <= 11'd0;
      cur_y        <= 11'd0;
      x0_q         <= 11'd0;
      x1_q         <= 11'd0;
      y1_q         <= 11'd0;
    end else begin
      case (state)
        IDLE: begin
          done     <= 1'b0;
          write_en <= 1'b0;
          if (paint_req) begin
            write_colour <= req_colour;
            x0_q         <= x0_c;
            x1_q         <= x1_c;
            y1_q         <= y1_c;
            if (out_of_grid) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state    <= STAMP;
              busy     <= 1'b1;
              write_en <= 1'b1;
              cur_x    <= x0_c;
              cur_y    <= y0_c;
              write_x  <= 10'(x0_c << CELL_SHIFT);
              write_y  <= 10'(y0_c << CELL_SHIFT);
            end
          end
        end
        STAMP: begin
          if (cur_x == x1_q) begin
            if (cur_y == y1_q) begin
              state    <= DONE;
              write_en <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
            end else begin
              cur_x   <= x0_q;
              cur_y   <= cur_y + 11'd1;
              write_x <= 10'(x0_q << CELL_SHIFT);
              write_y <= 10'((cur_y + 11'd1) << CELL_SHIFT);
            end
          end else begin
            cur_x   <= cur_x + 11'd1;
            write_x <= 10'((cur_x + 11'd1) << CELL_SHIFT);
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state    <= IDLE;
          write_en <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_brush_stamp_engine.sv
// tb/tb_brush_stamp_engine.sv - table-driven scoreboard bench for brush_stamp_engine.
// Define ERASER_EN to build and exercise the erase port.
module tb_brush_stamp_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        paint_req;
  logic [9:0]  cursor_x, cursor_y;
  logic [11:0] colour;
  logic [1:0]  brush_radius;
  logic        erase;
  logic        write_en;
  logic [9:0]  write_x, write_y;
  logic [11:0] write_colour;
  logic        busy, done;

  int checks = 0;
  int passes = 0;
  int n_writes = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_got, mon_exp;

  typedef struct {
    int px, py;
    logic [11:0] col;
    int rad;
    bit er;
    int n, fx, fy, lx, ly;
  } vec_t;

  vec_t vecs[9];

  brush_stamp_engine dut (
    .clk(clk), .reset(reset), .paint_req(paint_req),
    .cursor_x(cursor_x), .cursor_y(cursor_y), .colour(colour),
    .brush_radius(brush_radius),
`ifdef ERASER_EN
    .erase(erase),
`endif
    .write_en(write_en), .write_x(write_x), .write_y(write_y),
    .write_colour(write_colour), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, req);
  endtask

  task automatic push_model(input int px, input int py, input logic [11:0] col, input int rad);
    int cx, cy;
    cx = px / 8;
    cy = py / 8;
    if (cx >= 80 || cy >= 60) return;
    for (int y = ((cy - rad < 0) ? 0 : cy - rad); y <= ((cy + rad > 59) ? 59 : cy + rad); y++)
      for (int x = ((cx - rad < 0) ? 0 : cx - rad); x <= ((cx + rad > 79) ? 79 : cx + rad); x++)
        exp_q.push_back({10'(x * 8), 10'(y * 8), col});
  endtask

  always @(negedge clk) begin
    if (!reset && write_en) begin
      n_writes++;
      mon_got = {write_x, write_y, write_colour};
      if (exp_q.size() == 0) chk(1'b0, "unexpected_write", mon_got, 32'd0);
      else begin
        mon_exp = exp_q.pop_front();
        chk(mon_got == mon_exp, "write", mon_got, mon_exp);
      end
    end
  end

  task automatic run_vec(input vec_t v);
    int cyc, nw, done_cyc, first_cyc, fx, fy, lx, ly;
    bit busy_bad;
    @(negedge clk);
    cursor_x = 10'(v.px); cursor_y = 10'(v.py); colour = v.col;
    brush_radius = 2'(v.rad); erase = v.er; paint_req = 1'b1;
    push_model(v.px, v.py, v.er ? 12'hFFF : v.col, v.rad);
    @(negedge clk);
    paint_req = 1'b0;
    cursor_x = 10'($urandom); cursor_y = 10'($urandom); colour = 12'($urandom);
    brush_radius = 2'($urandom); erase = 1'($urandom);
    nw = 0; done_cyc = -1; first_cyc = -1; busy_bad = 0;
    fx = 0; fy = 0; lx = 0; ly = 0;
    for (cyc = 1; cyc <= 100; cyc++) begin
      if (busy !== write_en) busy_bad = 1;
      if (write_en) begin
        if (nw == 0) begin first_cyc = cyc; fx = write_x; fy = write_y; end
        lx = write_x; ly = write_y;
        nw++;
      end
      if (done) begin done_cyc = cyc; break; end
      @(negedge clk);
    end
    chk(done_cyc == v.n + 1, "done_cycle", done_cyc, v.n + 1);
    chk(nw == v.n, "write_count", nw, v.n);
    chk(!busy_bad, "busy_tracks_stamp", busy_bad, 0);
    if (v.n > 0) begin
      chk(first_cyc == 1, "first_latency", first_cyc, 1);
      chk(fx == v.fx && fy == v.fy, "first_xy", {fx[15:0], fy[15:0]}, {v.fx[15:0], v.fy[15:0]});
      chk(lx == v.lx && ly == v.ly, "last_xy", {lx[15:0], ly[15:0]}, {v.lx[15:0], v.ly[15:0]});
    end
    @(negedge clk);
    chk(done == 1'b0, "done_one_cycle", done, 0);
    if (v.n > 0) chk(write_x == 10'(v.lx) && write_y == 10'(v.ly), "xy_hold", {write_x, write_y}, {10'(v.lx), 10'(v.ly)});
    chk(exp_q.size() == 0, "queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    int base, cyc;
    bit bad;
    vec_t ev;
    vecs[0] = '{100, 50, 12'hF00, 0, 0, 1, 96, 48, 96, 48};
    vecs[1] = '{320, 240, 12'h0A5, 1, 0, 9, 312, 232, 328, 248};
    vecs[2] = '{0, 0, 12'h123, 2, 0, 9, 0, 0, 16, 16};
    vecs[3] = '{639, 479, 12'h456, 3, 0, 16, 608, 448, 632, 472};
    vecs[4] = '{700, 10, 12'h777, 1, 0, 0, 0, 0, 0, 0};
    vecs[5] = '{639, 0, 12'hABC, 1, 0, 4, 624, 0, 632, 8};
    vecs[6] = '{5, 475, 12'h00F, 2, 0, 9, 0, 456, 16, 472};
    vecs[7] = '{10, 600, 12'h321, 0, 0, 0, 0, 0, 0, 0};
    vecs[8] = '{47, 33, 12'h9C3, 1, 0, 9, 32, 24, 48, 40};

    reset = 1'b1; paint_req = 1'b0; cursor_x = 10'd0; cursor_y = 10'd0;
    colour = 12'd0; brush_radius = 2'd0; erase = 1'b0;
    repeat (3) @(negedge clk);
    chk(write_en == 1'b0 && busy == 1'b0 && done == 1'b0, "reset_flags", {write_en, busy, done}, 0);
    chk(write_x == 10'd0 && write_y == 10'd0 && write_colour == 12'd0, "reset_data",
        {write_x, write_y, write_colour}, 0);
    reset = 1'b0;

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

`ifdef ERASER_EN
    ev = '{200, 200, 12'h0F0, 1, 1, 9, 192, 192, 208, 208};
    run_vec(ev);
`endif

    // paint_req while busy and during the done cycle must be dropped
    base = n_writes;
    @(negedge clk);
    cursor_x = 10'd320; cursor_y = 10'd240; colour = 12'h5A5; brush_radius = 2'd1; erase = 1'b0;
    paint_req = 1'b1;
    push_model(320, 240, 12'h5A5, 1);
    @(negedge clk); paint_req = 1'b0;
    @(negedge clk); @(negedge clk);
    cursor_x = 10'd8; cursor_y = 10'd8; brush_radius = 2'd0; paint_req = 1'b1;
    @(negedge clk); paint_req = 1'b0;
    cyc = 0;
    while (!done && cyc < 50) begin @(negedge clk); cyc++; end
    chk(done == 1'b1, "busy_seq_done", done, 1);
    paint_req = 1'b1;
    @(negedge clk); paint_req = 1'b0;
    chk(write_en == 1'b0 && busy == 1'b0, "req_in_done_ignored", {write_en, busy}, 0);
    @(negedge clk);
    chk(n_writes - base == 9, "busy_req_count", n_writes - base, 9);
    chk(exp_q.size() == 0, "busy_queue_drained", exp_q.size(), 0);

    // asynchronous reset mid-stamp
    @(negedge clk);
    cursor_x = 10'd639; cursor_y = 10'd479; colour = 12'h456; brush_radius = 2'd3; paint_req = 1'b1;
    push_model(639, 479, 12'h456, 3);
    @(negedge clk); paint_req = 1'b0;
    repeat (4) @(negedge clk);
    chk(write_en == 1'b1, "mid_stamp_active", write_en, 1);
    #2 reset = 1'b1;
    #1;
    chk(write_en == 1'b0 && busy == 1'b0 && done == 1'b0, "async_reset_flags", {write_en, busy, done}, 0);
    chk(write_x == 10'd0 && write_y == 10'd0, "async_reset_xy", {write_x, write_y}, 0);
    exp_q.delete();
    @(negedge clk); reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (write_en || done || busy) bad = 1;
    end
    chk(!bad, "no_activity_after_reset", bad, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
